// File: rtl/note_mem_ctrl.sv
// note_mem_ctrl: packs UART bytes into 12-bit note words (3 bytes -> 2 words),
// buffers one packed pair and shares the single note RAM port between that
// write path and player reads. Player reads win every IDLE arbitration.
module note_mem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 520000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              load_clr,
  input  logic              play_req,
  input  logic [ADDR_W-1:0] play_addr,
  output logic              play_busy,
  output logic              play_valid,
  output logic [11:0]       play_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [11:0]       ram_wdata,
  input  logic [11:0]       ram_rdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic              frame_err,
  output logic              ovf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RD1, ST_RD2, ST_WR} state_e;

  // Packer / queue state. Only the two most recent bytes need storing: the
  // third byte of a triplet is consumed straight from rx_data.
  logic [1:0]        phase_q, phase_d;
  logic [15:0]       tmp_q, tmp_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [1:0]        q_cnt_q, q_cnt_d;
  logic [11:0]       q_w0_q, q_w0_d;   // queue head
  logic [11:0]       q_w1_q, q_w1_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              frame_err_q, frame_err_d;
  logic              ovf_q, ovf_d;

  // Arbiter state and registered RAM / player outputs.
  state_e            state_q;
  logic              ram_en_q, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [11:0]       ram_wdata_q;
  logic              play_busy_q, play_valid_q;
  logic [11:0]       play_rdata_q;

  logic              triplet_done;
  logic              pop;
  logic [11:0]       new_w0, new_w1;

  assign triplet_done = rx_valid && (phase_q == 2'd2);
  assign pop          = (state_q == ST_WR);
  assign new_w0       = tmp_q[15:4];
  assign new_w1       = {tmp_q[3:0], rx_data};

  // Next-state for byte packer, silence timer, word queue and write counters.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    phase_d     = phase_q;
    tmp_d       = tmp_q;
    timer_d     = timer_q;
    q_cnt_d     = q_cnt_q;
    q_w0_d      = q_w0_q;
    q_w1_d      = q_w1_q;
    wr_ptr_d    = wr_ptr_q;
    word_cnt_d  = word_cnt_q;
    frame_err_d = frame_err_q;
    ovf_d       = ovf_q;

    if (rx_valid) begin
      tmp_d   = {tmp_q[7:0], rx_data};
      timer_d = '0;
      phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
    end else if (phase_q == 2'd0) begin
      timer_d = '0;
    end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
      phase_d     = 2'd0;
      tmp_d       = '0;
      timer_d     = '0;
      frame_err_d = 1'b1;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    // The write issued on entry to WR retires here.
    if (pop) begin
      q_w0_d   = q_w1_q;
      q_cnt_d  = q_cnt_q - 2'd1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (word_cnt_q != CNT_W'(DEPTH)) word_cnt_d = word_cnt_q + 1'b1;
    end

    // Accept decision uses the pre-pop queue: a pair is taken whole or not at all.
    if (triplet_done) begin
      if (q_cnt_q == 2'd0 && word_cnt_q <= CNT_W'(DEPTH - 2)) begin
        q_w0_d  = new_w0;
        q_w1_d  = new_w1;
        q_cnt_d = 2'd2;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (load_clr) begin
      phase_d     = 2'd0;
      tmp_d       = '0;
      timer_d     = '0;
      q_cnt_d     = 2'd0;
      wr_ptr_d    = '0;
      word_cnt_d  = '0;
      frame_err_d = 1'b0;
      ovf_d       = 1'b0;
    end
  end

  // Packer / queue registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the queue words are only two registers, so they are reset like any other state.
    if (!rst_n) begin
      phase_q     <= 2'd0;
      tmp_q       <= '0;
      timer_q     <= '0;
      q_cnt_q     <= 2'd0;
      q_w0_q      <= '0;
      q_w1_q      <= '0;
      wr_ptr_q    <= '0;
      word_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      phase_q     <= phase_d;
      tmp_q       <= tmp_d;
      timer_q     <= timer_d;
      q_cnt_q     <= q_cnt_d;
      q_w0_q      <= q_w0_d;
      q_w1_q      <= q_w1_d;
      wr_ptr_q    <= wr_ptr_d;
      word_cnt_q  <= word_cnt_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
    end
  end

  // Arbiter FSM: RAM command registered on state entry, read data captured in RD2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      play_busy_q  <= 1'b0;
      play_valid_q <= 1'b0;
      play_rdata_q <= '0;
    end else begin
      play_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (play_req) begin
            state_q     <= ST_RD1;
            ram_en_q    <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= play_addr;
            play_busy_q <= 1'b1;
          end else if (q_cnt_q != 2'd0 && !load_clr) begin
            state_q     <= ST_WR;
            ram_en_q    <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= wr_ptr_q;
            ram_wdata_q <= q_w0_q;
          end
        end
        ST_RD1: begin
          ram_en_q <= 1'b0;
          state_q  <= ST_RD2;
        end
        ST_RD2: begin
          play_rdata_q <= ram_rdata;
          play_valid_q <= 1'b1;
          play_busy_q  <= 1'b0;
          state_q      <= ST_IDLE;
        end
        ST_WR: begin
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign play_busy  = play_busy_q;
  assign play_valid = play_valid_q;
  assign play_rdata = play_rdata_q;
  assign word_cnt   = word_cnt_q;
  assign frame_err  = frame_err_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_note_mem_ctrl.sv
// Scoreboard bench for note_mem_ctrl: directed stimulus pushes expected RAM
// writes and player reads into queues; a negedge monitor pops and compares.
module tb_note_mem_ctrl;

  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              load_clr = 1'b0;
  logic              play_req = 1'b0;
  logic [ADDR_W-1:0] play_addr = '0;
  logic              play_busy, play_valid;
  logic [11:0]       play_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [11:0]       ram_wdata;
  logic [11:0]       ram_rdata = '0;
  logic [ADDR_W:0]   word_cnt;
  logic              frame_err, ovf;

  note_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .load_clr(load_clr),
    .play_req(play_req), .play_addr(play_addr),
    .play_busy(play_busy), .play_valid(play_valid), .play_rdata(play_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .word_cnt(word_cnt), .frame_err(frame_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural note RAM, 1-cycle read latency.
  logic [11:0] mem [2**ADDR_W];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct { logic [ADDR_W-1:0] addr; logic [11:0] data; } wr_t;
  typedef struct { logic [11:0] data; int cyc; } rd_t;
  wr_t wq[$];
  rd_t rq[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every RAM write and every play_valid strobe must match the next expectation.
  wr_t we;
  rd_t re;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_en && ram_we) begin
        if (wq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data 0x%03h, no write expected", ram_addr, ram_wdata);
        end else begin
          we = wq.pop_front();
          check("wr_addr", 64'(ram_addr), 64'(we.addr));
          check("wr_data", 64'(ram_wdata), 64'(we.data));
        end
      end
      if (play_valid) begin
        if (rq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read: play_rdata 0x%03h, no read expected", play_rdata);
        end else begin
          re = rq.pop_front();
          check("rd_data", 64'(play_rdata), 64'(re.data));
          check("rd_latency", 64'(cyc), 64'(re.cyc));
        end
      end
    end
  end

  function automatic logic [63:0] outs();
    return 64'({ram_en, ram_we, ram_addr, ram_wdata, play_busy, play_valid,
                play_rdata, word_cnt, frame_err, ovf});
  endfunction

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [11:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wq.push_back(e);
  endtask

  // Called at a negedge; returns at a negedge with one idle cycle after the strobe.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send(b0);
    send(b1);
    send(b2);
  endtask

  task automatic wait_cnt(input string name, input int exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (word_cnt == exp[ADDR_W:0]) break;
      @(negedge clk);
    end
    check(name, 64'(word_cnt), 64'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rd_t r;
    bit  seen;

    // Reset state, during and just after reset.
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outs", outs(), 64'd0);

    // 1: 0x12,0x34,0x56 -> addr0=0x123, addr1=0x456.
    expect_wr(0, 12'h123);
    expect_wr(1, 12'h456);
    send3(8'h12, 8'h34, 8'h56);
    wait_cnt("t1_word_cnt", 2, 20);

    // 2: read addr 1, valid exactly 3 cycles after request; request while busy ignored.
    play_addr = 1;
    play_req  = 1'b1;
    r.data = 12'h456;
    r.cyc  = cyc + 3;
    rq.push_back(r);
    @(negedge clk);
    play_req = 1'b0;
    check("t2_busy_rd1", 64'(play_busy), 64'd1);
    play_addr = 0;
    play_req  = 1'b1;
    @(negedge clk);
    play_req = 1'b0;
    check("t2_busy_rd2", 64'(play_busy), 64'd1);
    @(negedge clk);
    check("t2_busy_done", 64'(play_busy), 64'd0);
    idle(3);

    // 3: triplet completes with play_req in the same cycle: read goes first.
    expect_wr(2, 12'h9AB);
    expect_wr(3, 12'hCDE);
    send(8'h9A);
    send(8'hBC);
    rx_data   = 8'hDE;
    rx_valid  = 1'b1;
    play_addr = 0;
    play_req  = 1'b1;
    r.data = 12'h123;
    r.cyc  = cyc + 3;
    rq.push_back(r);
    @(negedge clk);
    rx_valid = 1'b0;
    play_req = 1'b0;
    check("t3_read_first", 64'({ram_en, ram_we}), 64'b10);
    wait_cnt("t3_word_cnt", 4, 20);
    check("t3_no_ovf", 64'(ovf), 64'd0);

    // 5: memory full -> third triplet dropped, ovf set, count stays at DEPTH.
    send3(8'h01, 8'h02, 8'h03);
    idle(4);
    check("t5_ovf", 64'(ovf), 64'd1);
    check("t5_word_cnt", 64'(word_cnt), 64'd4);

    load_clr = 1'b1;
    @(negedge clk);
    load_clr = 1'b0;
    check("clr_state", 64'({word_cnt, ovf, frame_err}), 64'd0);

    // 4: single byte then silence -> frame_err only after TIMEOUT cycles.
    send(8'hAB);
    idle(11);
    check("t4_no_early_timeout", 64'(frame_err), 64'd0);
    idle(6);
    check("t4_frame_err", 64'(frame_err), 64'd1);
    expect_wr(0, 12'h112);
    expect_wr(1, 12'h233);
    send3(8'h11, 8'h22, 8'h33);
    wait_cnt("t4_word_cnt", 2, 20);
    check("t4_frame_err_sticky", 64'(frame_err), 64'd1);

    // 6a: load_clr mid-triplet, and it beats a same-cycle rx_valid.
    send(8'h77);
    load_clr = 1'b1;
    rx_data  = 8'h99;
    rx_valid = 1'b1;
    @(negedge clk);
    load_clr = 1'b0;
    rx_valid = 1'b0;
    check("t6_clr", 64'({word_cnt, frame_err}), 64'd0);
    expect_wr(0, 12'h123);
    expect_wr(1, 12'h456);
    send3(8'h12, 8'h34, 8'h56);
    wait_cnt("t6_clr_word_cnt", 2, 20);

    // 6b: async reset while in RD1.
    play_addr = 1;
    play_req  = 1'b1;
    @(negedge clk);
    play_req = 1'b0;
    check("t6_in_rd1", 64'({ram_en, ram_we, play_busy}), 64'b101);
    #2 rst_n = 1'b0;
    #1 check("t6_rst_rd1_outs", outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 6c: async reset while in WR; only W0 reaches the RAM.
    expect_wr(0, 12'hAAB);
    send(8'hAA);
    send(8'hBB);
    rx_data  = 8'hCC;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ram_en && ram_we) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t6_wr_seen", 64'(seen), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("t6_rst_wr_outs", outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_wr(0, 12'h5A5);
    expect_wr(1, 12'hB5C);
    send3(8'h5A, 8'h5B, 8'h5C);
    wait_cnt("t6_post_rst_word_cnt", 2, 20);

    idle(5);
    check("wr_queue_drained", 64'(wq.size()), 64'd0);
    check("rd_queue_drained", 64'(rq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
